// File: rtl/apb4_slave_regfile.sv
// APB4 completer register file: byte strobes, PSLVERR, programmable wait states and a read-only ID in reg 0.
// Optional build macro APB_WAKEUP_CHECK_EN: a setup with PWAKEUP=0 completes with PSLVERR=1.
module apb4_slave_regfile #(
   parameter int          ADDR_WIDTH  = 12,
   parameter int          DATA_WIDTH  = 32,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   input  logic [ADDR_WIDTH-1:0]          PADDR,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [DATA_WIDTH-1:0]          PWDATA,
   input  logic [DATA_WIDTH/8-1:0]        PSTRB,
   input  logic                           PWAKEUP,
   output logic [DATA_WIDTH-1:0]          PRDATA,
   output logic                           PREADY,
   output logic                           PSLVERR,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int BYTE_OFFS  = $clog2(STRB_WIDTH);
   localparam int IDX_WIDTH  = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << BYTE_OFFS) - 1);
   localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
   localparam logic [3:0]            WAIT_CNT   = 4'(WAIT_STATES);
   localparam logic [DATA_WIDTH-1:0] ID_DATA    = ID_VALUE[DATA_WIDTH-1:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_r;
   logic [3:0]              cnt_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic                    write_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic [STRB_WIDTH-1:0]   strb_r;
   logic [DATA_WIDTH-1:0]   prdata_r;
   logic                    pready_r;
   logic                    pslverr_r;
   logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];

   logic                    setup_s;
   logic                    access_s;
   logic                    complete_s;
   logic                    err_s;
   logic [ADDR_WIDTH-1:0]   cur_addr_s;
   logic                    cur_write_s;
   logic [DATA_WIDTH-1:0]   cur_wdata_s;
   logic [STRB_WIDTH-1:0]   cur_strb_s;
   logic [IDX_WIDTH-1:0]    cur_idx_s;

`ifdef APB_WAKEUP_CHECK_EN
   logic                    wakeup_r;
   logic                    cur_wakeup_s;
`else
   logic                    unused_wakeup_s;
   assign unused_wakeup_s = PWAKEUP;
`endif

   function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] a);
      return ((a & ALIGN_MASK) == {ADDR_WIDTH{1'b0}}) && ((a >> BYTE_OFFS) < NUM_REGS_A);
   endfunction

   function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] word;
      word = a >> BYTE_OFFS;
      return word[IDX_WIDTH-1:0];
   endfunction

   // Transfer-source select, completion detect and error decode.
   always_comb begin
      setup_s  = PSEL & ~PENABLE;
      access_s = PSEL & PENABLE;
      // A zero-wait transfer completes on its setup edge, so it decodes the live bus.
      if (state_r == ST_IDLE) begin
         cur_addr_s  = PADDR;
         cur_write_s = PWRITE;
         cur_wdata_s = PWDATA;
         cur_strb_s  = PSTRB;
`ifdef APB_WAKEUP_CHECK_EN
         cur_wakeup_s = PWAKEUP;
`endif
      end else begin
         cur_addr_s  = addr_r;
         cur_write_s = write_r;
         cur_wdata_s = wdata_r;
         cur_strb_s  = strb_r;
`ifdef APB_WAKEUP_CHECK_EN
         cur_wakeup_s = wakeup_r;
`endif
      end
      case (state_r)
         ST_IDLE: complete_s = setup_s && (WAIT_CNT == 4'd0);
         ST_WAIT: complete_s = access_s && (cnt_r <= 4'd1);
         default: complete_s = 1'b0;
      endcase
      cur_idx_s = addr_index(cur_addr_s);
      err_s     = !addr_valid(cur_addr_s) || (cur_write_s && (cur_idx_s == {IDX_WIDTH{1'b0}}));
`ifdef APB_WAKEUP_CHECK_EN
      err_s     = err_s || !cur_wakeup_s;
`endif
   end

   // Transfer FSM, register array and registered APB response.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_r   <= ST_IDLE;
         cnt_r     <= 4'd0;
         addr_r    <= {ADDR_WIDTH{1'b0}};
         write_r   <= 1'b0;
         wdata_r   <= {DATA_WIDTH{1'b0}};
         strb_r    <= {STRB_WIDTH{1'b0}};
         prdata_r  <= {DATA_WIDTH{1'b0}};
         pready_r  <= 1'b0;
         pslverr_r <= 1'b0;
`ifdef APB_WAKEUP_CHECK_EN
         wakeup_r  <= 1'b0;
`endif
         regs_r[0] <= ID_DATA;
         for (int k = 1; k < NUM_REGS; k++) begin
            regs_r[k] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (setup_s) begin
                  addr_r  <= PADDR;
                  write_r <= PWRITE;
                  wdata_r <= PWDATA;
                  strb_r  <= PSTRB;
`ifdef APB_WAKEUP_CHECK_EN
                  wakeup_r <= PWAKEUP;
`endif
                  cnt_r   <= WAIT_CNT;
                  state_r <= complete_s ? ST_DONE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!access_s) begin
                  state_r <= ST_IDLE;
               end else if (complete_s) begin
                  state_r <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            ST_DONE: begin
               state_r   <= ST_IDLE;
               pready_r  <= 1'b0;
               pslverr_r <= 1'b0;
            end
            default: state_r <= ST_IDLE;
         endcase
         if (complete_s) begin
            pready_r <= 1'b1;
            if (err_s) begin
               pslverr_r <= 1'b1;
               prdata_r  <= {DATA_WIDTH{1'b0}};
            end else if (cur_write_s) begin
               pslverr_r <= 1'b0;
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (cur_strb_s[b]) begin
                     regs_r[cur_idx_s][b*8 +: 8] <= cur_wdata_s[b*8 +: 8];
                  end
               end
            end else begin
               pslverr_r <= 1'b0;
               prdata_r  <= regs_r[cur_idx_s];
            end
         end
      end
   end

   assign PRDATA  = prdata_r;
   assign PREADY  = pready_r;
   assign PSLVERR = pslverr_r;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
      assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_r[k];
   end

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Self-checking bench for apb4_slave_regfile: directed scenarios plus randomized transfers
// against an array-based register model.
module tb_apb4_slave_regfile;

   localparam int          AW = 12;
   localparam int          DW = 32;
   localparam int          NR = 16;
   localparam int          WS = 2;
   localparam logic [31:0] ID = 32'hA9B0_0001;
`ifdef APB_WAKEUP_CHECK_EN
   localparam bit WAKE_EN = 1'b1;
`else
   localparam bit WAKE_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           preset = 1'b1;
   logic [AW-1:0]  paddr = '0;
   logic           psel = 1'b0;
   logic           penable = 1'b0;
   logic           pwrite = 1'b0;
   logic [DW-1:0]  pwdata = '0;
   logic [DW/8-1:0] pstrb = '0;
   logic           pwakeup = 1'b1;
   logic [DW-1:0]  prdata;
   logic           pready;
   logic           pslverr;
   logic [NR*DW-1:0] reg_out;

   int unsigned cyc = 0;
   int n_checks = 0;
   int n_pass = 0;

   logic [31:0] model_regs [NR];
   logic [31:0] exp_prdata;

   apb4_slave_regfile #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(WS), .ID_VALUE(ID)
   ) dut (
      .PCLK(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PWAKEUP(pwakeup),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .reg_out(reg_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic model_valid(input logic [11:0] a);
      return (a % 4 == 0) && (a / 4 < NR);
   endfunction

   function automatic logic model_err(input logic [11:0] a, input logic w, input logic wk);
      return !model_valid(a) || (w && (a / 4 == 0)) || (WAKE_EN && !wk);
   endfunction

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      for (int k = 0; k < NR; k++) f[k*DW +: DW] = model_regs[k];
      return f;
   endfunction

   task automatic model_reset();
      model_regs[0] = ID;
      for (int k = 1; k < NR; k++) model_regs[k] = 32'h0;
      exp_prdata = 32'h0;
   endtask

   // Apply one completed transfer to the model; returns the expected PSLVERR.
   task automatic model_apply(input logic [11:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input logic wk, output logic e);
      logic [31:0] mask;
      e = model_err(a, w, wk);
      if (e) begin
         exp_prdata = 32'h0;
      end else if (w) begin
         mask = 32'h0;
         for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
         model_regs[a / 4] = (model_regs[a / 4] & ~mask) | (d & mask);
      end else begin
         exp_prdata = model_regs[a / 4];
      end
   endtask

   // Setup + access phases; leaves the bus in the completing access phase.
   task automatic apb_xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic wk,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int unsigned rdy_cyc);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s; pwakeup = wk;
      @(posedge clk); #1;
      penable = 1'b1; lat = 1;
      paddr = 12'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
      while (pready !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         paddr = 12'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
      end
      rd = prdata; er = pslverr; rdy_cyc = cyc;
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      preset = 1'b1;
      repeat (3) @(posedge clk);
      #1 preset = 1'b0;
      model_reset();
      n_checks++; if (prdata !== 32'h0) $display("FAIL reset_prdata got %h exp %h", prdata, 32'h0); else n_pass++;
      n_checks++; if (pready !== 1'b0) $display("FAIL reset_pready got %b exp 0", pready); else n_pass++;
      n_checks++; if (pslverr !== 1'b0) $display("FAIL reset_pslverr got %b exp 0", pslverr); else n_pass++;
      n_checks++; if (reg_out !== model_flat()) $display("FAIL reset_reg_out got %h exp %h", reg_out, model_flat()); else n_pass++;
   endtask

   task automatic test_id_read();
      logic [31:0] rd; logic er; int lat; int unsigned rc;
      apb_xfer(12'h000, 1'b0, 32'h0, 4'hF, 1'b1, rd, er, lat, rc);
      n_checks++; if (lat != 1 + WS) $display("FAIL id_latency got %0d exp %0d", lat, 1 + WS); else n_pass++;
      n_checks++; if (rd !== ID) $display("FAIL id_prdata got %h exp %h", rd, ID); else n_pass++;
      n_checks++; if (er !== 1'b0) $display("FAIL id_pslverr got %b exp 0", er); else n_pass++;
      apb_xfer(12'h004, 1'b0, 32'h0, 4'h0, 1'b1, rd, er, lat, rc);
      n_checks++; if (rd !== 32'h0) $display("FAIL read4_prdata got %h exp 0", rd); else n_pass++;
      bus_idle();
   endtask

   task automatic test_strobes();
      logic [31:0] rd; logic er; int lat; int unsigned rc;
      apb_xfer(12'h008, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b1, rd, er, lat, rc);
      model_apply(12'h008, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b1, er);
      apb_xfer(12'h008, 1'b1, 32'h0000_5500, 4'b0010, 1'b1, rd, er, lat, rc);
      model_apply(12'h008, 1'b1, 32'h0000_5500, 4'b0010, 1'b1, er);
      n_checks++; if (er !== 1'b0) $display("FAIL strobe_write_err got %b exp 0", er); else n_pass++;
      apb_xfer(12'h008, 1'b0, 32'h0, 4'h0, 1'b1, rd, er, lat, rc);
      model_apply(12'h008, 1'b0, 32'h0, 4'h0, 1'b1, er);
      n_checks++; if (rd !== 32'hDEAD_55EF) $display("FAIL strobe_prdata got %h exp %h", rd, 32'hDEAD_55EF); else n_pass++;
      n_checks++; if (reg_out[95:64] !== 32'hDEAD_55EF) $display("FAIL strobe_reg_out got %h exp %h", reg_out[95:64], 32'hDEAD_55EF); else n_pass++;
      bus_idle();
   endtask

   task automatic test_errors();
      logic [11:0] addrs [3];
      logic [31:0] rd; logic er; int lat; int unsigned rc;
      addrs[0] = 12'h040; addrs[1] = 12'h006; addrs[2] = 12'h000;
      for (int i = 0; i < 3; i++) begin
         apb_xfer(addrs[i], 1'b1, 32'h5A5A_A5A5, 4'hF, 1'b1, rd, er, lat, rc);
         n_checks++; if (er !== 1'b1) $display("FAIL err_pslverr addr %h got %b exp 1", addrs[i], er); else n_pass++;
         n_checks++; if (rd !== 32'h0) $display("FAIL err_prdata addr %h got %h exp 0", addrs[i], rd); else n_pass++;
         n_checks++; if (reg_out !== model_flat()) $display("FAIL err_regs addr %h got %h exp %h", addrs[i], reg_out, model_flat()); else n_pass++;
         bus_idle();
      end
      exp_prdata = 32'h0;
      n_checks++; if (reg_out[31:0] !== ID) $display("FAIL err_id got %h exp %h", reg_out[31:0], ID); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat; int unsigned rc1, rc2;
      apb_xfer(12'h010, 1'b1, 32'h1234_5678, 4'hF, 1'b1, rd, er, lat, rc1);
      model_apply(12'h010, 1'b1, 32'h1234_5678, 4'hF, 1'b1, er);
      apb_xfer(12'h010, 1'b0, 32'h0, 4'h0, 1'b1, rd, er, lat, rc2);
      model_apply(12'h010, 1'b0, 32'h0, 4'h0, 1'b1, er);
      n_checks++; if (rc2 - rc1 != 4) $display("FAIL b2b_gap got %0d exp 4", rc2 - rc1); else n_pass++;
      n_checks++; if (rd !== 32'h1234_5678) $display("FAIL b2b_prdata got %h exp %h", rd, 32'h1234_5678); else n_pass++;
      bus_idle();
      n_checks++; if (pready !== 1'b0) $display("FAIL b2b_pready_drop got %b exp 0", pready); else n_pass++;
      n_checks++; if (prdata !== 32'h1234_5678) $display("FAIL b2b_prdata_hold got %h exp %h", prdata, 32'h1234_5678); else n_pass++;
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic er; int lat; int unsigned rc;
      logic seen;
      // PENABLE dropped in the cycle that would otherwise commit
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 12'h00C; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 penable = 1'b0;
      seen = pready;
      repeat (6) begin
         @(posedge clk); #1;
         psel = 1'b0;
         seen = seen | pready;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL abort_pready got %b exp 0", seen); else n_pass++;
      apb_xfer(12'h00C, 1'b0, 32'h0, 4'h0, 1'b1, rd, er, lat, rc);
      model_apply(12'h00C, 1'b0, 32'h0, 4'h0, 1'b1, er);
      n_checks++; if (rd !== model_regs[3]) $display("FAIL abort_read got %h exp %h", rd, model_regs[3]); else n_pass++;
      bus_idle();
      // reset held across the would-be commit edge
      apb_xfer(12'h014, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, rd, er, lat, rc);
      model_apply(12'h014, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, er);
      bus_idle();
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 12'h00C; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 preset = 1'b1;
      seen = pready;
      @(posedge clk); #1;
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      seen = seen | pready;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | pready;
      end
      model_reset();
      n_checks++; if (seen !== 1'b0) $display("FAIL rst_abort_pready got %b exp 0", seen); else n_pass++;
      n_checks++; if (reg_out !== model_flat()) $display("FAIL rst_abort_regs got %h exp %h", reg_out, model_flat()); else n_pass++;
      apb_xfer(12'h00C, 1'b0, 32'h0, 4'h0, 1'b1, rd, er, lat, rc);
      model_apply(12'h00C, 1'b0, 32'h0, 4'h0, 1'b1, er);
      n_checks++; if (rd !== 32'h0) $display("FAIL rst_abort_read got %h exp 0", rd); else n_pass++;
      bus_idle();
   endtask

   task automatic test_wakeup();
      logic [31:0] rd; logic er, ee; int lat; int unsigned rc;
      for (int wk = 0; wk < 2; wk++) begin
         apb_xfer(12'h004, 1'b1, 32'h1 + 32'(wk), 4'hF, 1'(wk), rd, er, lat, rc);
         model_apply(12'h004, 1'b1, 32'h1 + 32'(wk), 4'hF, 1'(wk), ee);
         n_checks++; if (er !== ee) $display("FAIL wake%0d_pslverr got %b exp %b", wk, er, ee); else n_pass++;
         apb_xfer(12'h004, 1'b0, 32'h0, 4'h0, 1'b1, rd, er, lat, rc);
         model_apply(12'h004, 1'b0, 32'h0, 4'h0, 1'b1, ee);
         n_checks++; if (rd !== exp_prdata) $display("FAIL wake%0d_read got %h exp %h", wk, rd, exp_prdata); else n_pass++;
         bus_idle();
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, d; logic er, ee, w, wk; logic [11:0] a; logic [3:0] s;
      int lat; int unsigned rc;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 7) a = 12'(4 * $urandom_range(0, NR + 1));
         else a = 12'($urandom);
         w  = 1'($urandom);
         d  = $urandom;
         s  = 4'($urandom);
         wk = ($urandom_range(0, 3) != 0);
         apb_xfer(a, w, d, s, wk, rd, er, lat, rc);
         model_apply(a, w, d, s, wk, ee);
         n_checks++; if (lat != 1 + WS) $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, 1 + WS); else n_pass++;
         n_checks++; if (er !== ee) $display("FAIL rnd%0d_pslverr addr %h w %b got %b exp %b", i, a, w, er, ee); else n_pass++;
         n_checks++; if (rd !== exp_prdata) $display("FAIL rnd%0d_prdata addr %h got %h exp %h", i, a, rd, exp_prdata); else n_pass++;
         n_checks++; if (reg_out !== model_flat()) $display("FAIL rnd%0d_reg_out got %h exp %h", i, reg_out, model_flat()); else n_pass++;
         if ($urandom_range(0, 1) == 0) bus_idle();
      end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_id_read();
      test_strobes();
      test_errors();
      test_back_to_back();
      test_abort();
      test_wakeup();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
